// File: rtl/pldata_writer_pkg.sv
// Shared types and constants for the PL data frame writer.
package pldata_writer_pkg;
    typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} wr_state_t;

    localparam logic [15:0] HDR_MAGIC   = 16'hA5A5;
    localparam int          BYTE_STRIDE = 4;
endpackage

// File: rtl/pldata_frame_writer_sample_packer.sv
// 16->32 pair assembler: low sample is held until its partner arrives or a flush
// pushes it out zero-extended.
module sample_packer #(
    parameter int SAMPLE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [SAMPLE_W-1:0]   in_data,
    input  logic                  flush,
    output logic                  word_valid,
    output logic [2*SAMPLE_W-1:0] word_data
);
    logic                have_lo;
    logic [SAMPLE_W-1:0] lo;

    always_comb begin
        word_valid = have_lo && (in_valid || flush);
        word_data  = flush ? {{SAMPLE_W{1'b0}}, lo} : {in_data, lo};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            have_lo <= 1'b0;
            lo      <= '0;
        end else if (flush) begin
            have_lo <= 1'b0;
        end else if (in_valid) begin
            have_lo <= !have_lo;
            if (!have_lo) lo <= in_data;
        end
    end
endmodule

// File: rtl/pldata_frame_writer.sv
// Frame writer: packs sample pairs into 32-bit words and ping-pongs frames across the two
// BRAM halves. Define PLDATA_FRAME_HEADER_EN to put {A5A5, frame count} in word 0 of each frame.
module pldata_frame_writer
    import pldata_writer_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int SAMPLE_W    = 16,
    parameter int FRAME_WORDS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_in,
    input  logic                frame_end_in,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid_in,
    input  logic                irq_ack_in,
    output logic                ram_wr_o,
    output logic [ADDR_W-1:0]   ram_addr_o,
    output logic [31:0]         ram_data_o,
    output logic                frame_done_o,
    output logic                irq_o,
    output logic                buf_sel_o,
    output logic                overflow_o,
    output logic [15:0]         frame_cnt_o
);
    localparam int LSB_W = $clog2(BYTE_STRIDE);
    localparam int IDX_W = ADDR_W - LSB_W - 1;
    // one extra bit so the count can reach FRAME_WORDS itself
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_WORDS - 1);

    wr_state_t             state;
    logic                  half;
    logic [CNT_W-1:0]      word_cnt;
    logic                  pk_valid;
    logic [2*SAMPLE_W-1:0] pk_data;

    sample_packer #(.SAMPLE_W(SAMPLE_W)) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (sample_valid_in && (state == FILL)),
        .in_data    (sample_in),
        .flush      (state == FLUSH),
        .word_valid (pk_valid),
        .word_data  (pk_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            half         <= 1'b0;
            word_cnt     <= '0;
            ram_wr_o     <= 1'b0;
            ram_addr_o   <= '0;
            ram_data_o   <= '0;
            frame_done_o <= 1'b0;
            irq_o        <= 1'b0;
            buf_sel_o    <= 1'b0;
            overflow_o   <= 1'b0;
            frame_cnt_o  <= '0;
        end else begin
            ram_wr_o     <= 1'b0;
            frame_done_o <= 1'b0;
            if (irq_ack_in) irq_o <= 1'b0;

            if (pk_valid) begin
                ram_wr_o   <= 1'b1;
                ram_addr_o <= {half, word_cnt[IDX_W-1:0], {LSB_W{1'b0}}};
                ram_data_o <= pk_data;
                word_cnt   <= word_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: if (start_in) begin
                    state <= FILL;
`ifdef PLDATA_FRAME_HEADER_EN
                    ram_wr_o   <= 1'b1;
                    ram_addr_o <= {half, {IDX_W{1'b0}}, {LSB_W{1'b0}}};
                    ram_data_o <= {HDR_MAGIC, frame_cnt_o};
                    word_cnt   <= CNT_W'(1);
`else
                    word_cnt   <= '0;
`endif
                end
                FILL: if (frame_end_in || (pk_valid && word_cnt == LAST_WORD)) state <= FLUSH;
                FLUSH: begin
                    state        <= DONE;
                    frame_done_o <= 1'b1;
                end
                DONE: begin
                    // assigned after the ack clear so a coincident ack loses
                    irq_o       <= 1'b1;
                    buf_sel_o   <= half;
                    half        <= !half;
                    frame_cnt_o <= frame_cnt_o + 16'd1;
                    if (irq_o && !irq_ack_in) overflow_o <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pldata_frame_writer.sv
// Randomized bench for pldata_frame_writer against a frame-level reference model.
module tb_pldata_frame_writer;
    localparam int AW = 10;
    localparam int FW = 4;
`ifdef PLDATA_FRAME_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int CAP = FW - HDR;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_in = 1'b0;
    logic          frame_end_in = 1'b0;
    logic [15:0]   sample_in = '0;
    logic          sample_valid_in = 1'b0;
    logic          irq_ack_in = 1'b0;
    logic          ram_wr_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0]   ram_data_o;
    logic          frame_done_o, irq_o, buf_sel_o, overflow_o;
    logic [15:0]   frame_cnt_o;

    int tests = 0;
    int fails = 0;
    int done_seen = 0;
    logic [AW+31:0] got[$];
    logic [AW+31:0] exp_q[$];
    logic [15:0]    smp[$];
    bit             m_half, m_irq, m_ovf, m_bsel;
    logic [15:0]    m_cnt;

    pldata_frame_writer #(.ADDR_W(AW), .SAMPLE_W(16), .FRAME_WORDS(FW)) dut (
        .clk(clk), .rst_n(rst_n), .start_in(start_in), .frame_end_in(frame_end_in),
        .sample_in(sample_in), .sample_valid_in(sample_valid_in), .irq_ack_in(irq_ack_in),
        .ram_wr_o(ram_wr_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
        .frame_done_o(frame_done_o), .irq_o(irq_o), .buf_sel_o(buf_sel_o),
        .overflow_o(overflow_o), .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n) begin
        if (ram_wr_o) got.push_back({ram_addr_o, ram_data_o});
        if (frame_done_o) done_seen++;
    end

    task automatic model_reset();
        m_half = 0; m_irq = 0; m_ovf = 0; m_bsel = 0; m_cnt = '0;
    endtask

    // Expected writes of one frame of n accepted samples, then the commit bookkeeping.
    task automatic model_frame(input int n, input bit ack);
        int w = 0;
        int base = m_half ? (1 << (AW - 1)) : 0;
        exp_q.delete();
        if (HDR != 0) begin
            exp_q.push_back({AW'(base), 16'hA5A5, m_cnt});
            w = 1;
        end
        for (int i = 0; i + 1 < n; i += 2) begin
            exp_q.push_back({AW'(base + 4 * w), smp[i+1], smp[i]});
            w++;
        end
        if (n % 2 == 1) exp_q.push_back({AW'(base + 4 * w), 16'h0000, smp[n-1]});
        if (m_irq && !ack) m_ovf = 1;
        m_irq = 1; m_bsel = m_half; m_half = !m_half; m_cnt++;
    endtask

    task automatic fill_random(input int n);
        smp.delete();
        for (int i = 0; i < n; i++) smp.push_back(16'($urandom));
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Drives one frame; ok=0 if frame_done never shows up within the budget.
    task automatic run_frame(input int n, input bit early, input bit end_last, input bit extra,
                             input bit ack_done, input bit stray, output bit ok);
        ok = 0;
        got.delete();
        @(posedge clk); #1 start_in = 1;
        @(posedge clk); #1 start_in = 0;
        for (int i = 0; i < n; i++) begin
            gap();
            sample_valid_in = 1;
            sample_in       = smp[i];
            frame_end_in    = early && end_last && (i == n - 1);
            start_in        = stray && (i == 1);
            @(posedge clk); #1;
            sample_valid_in = 0; frame_end_in = 0; start_in = 0;
        end
        if (early && !end_last) begin
            gap();
            frame_end_in = 1;
            @(posedge clk); #1 frame_end_in = 0;
        end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (frame_done_o) begin ok = 1; break; end
            if (extra) begin sample_valid_in = 1; sample_in = 16'($urandom); end
        end
        sample_valid_in = 0;
        if (ok && ack_done) irq_ack_in = 1;
        @(posedge clk); #1 irq_ack_in = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({ram_wr_o, ram_addr_o, ram_data_o, frame_done_o, irq_o, buf_sel_o, overflow_o, frame_cnt_o} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got wr=%0b addr=%h data=%h done=%0b irq=%0b sel=%0b ovf=%0b cnt=%h want all zero",
                     ram_wr_o, ram_addr_o, ram_data_o, frame_done_o, irq_o, buf_sel_o, overflow_o, frame_cnt_o);
        end
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_full_frame();
        bit ok;
        int d0 = done_seen;
        smp.delete();
        for (int i = 1; i <= 2 * CAP; i++) smp.push_back(16'(i));
        run_frame(2 * CAP, 0, 0, 1, 0, 1, ok);
        model_frame(2 * CAP, 0);
        tests++; if (!ok) begin fails++; $display("FAIL full_timeout no frame_done want one"); end
        tests++; if (done_seen - d0 != 1) begin fails++; $display("FAIL full_done_pulses got %0d want 1", done_seen - d0); end
        tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL full_wr_count got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            tests++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL full_wr[%0d] got %h want %h", i, got[i], exp_q[i]); end
        end
        tests++;
        if ({irq_o, buf_sel_o, overflow_o, frame_cnt_o} !== {m_irq, m_bsel, m_ovf, m_cnt}) begin
            fails++; $display("FAIL full_status got irq=%0b sel=%0b ovf=%0b cnt=%0d want %0b %0b %0b %0d",
                              irq_o, buf_sel_o, overflow_o, frame_cnt_o, m_irq, m_bsel, m_ovf, m_cnt);
        end
    endtask

    // Second frame, no ack in between: upper half, buf_sel=1, overflow set.
    task automatic test_ping_pong_overflow();
        bit ok;
        fill_random(2 * CAP);
        run_frame(2 * CAP, 0, 0, 0, 0, 0, ok);
        model_frame(2 * CAP, 0);
        tests++; if (!ok) begin fails++; $display("FAIL pp_timeout no frame_done want one"); end
        tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL pp_wr_count got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            tests++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL pp_wr[%0d] got %h want %h", i, got[i], exp_q[i]); end
        end
        tests++;
        if ({irq_o, buf_sel_o, overflow_o, frame_cnt_o} !== {m_irq, m_bsel, m_ovf, m_cnt}) begin
            fails++; $display("FAIL pp_status got irq=%0b sel=%0b ovf=%0b cnt=%0d want %0b %0b %0b %0d",
                              irq_o, buf_sel_o, overflow_o, frame_cnt_o, m_irq, m_bsel, m_ovf, m_cnt);
        end
    endtask

    task automatic test_early_end();
        bit ok;
        smp.delete();
        smp.push_back(16'h000A); smp.push_back(16'h000B); smp.push_back(16'h000C);
        run_frame(3, 1, 1, 0, 0, 0, ok);
        model_frame(3, 0);
        tests++; if (!ok) begin fails++; $display("FAIL early_timeout no frame_done want one"); end
        tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL early_wr_count got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            tests++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL early_wr[%0d] got %h want %h", i, got[i], exp_q[i]); end
        end
        // even count with a separate end pulse: no flush write
        smp.delete();
        smp.push_back(16'h1111); smp.push_back(16'h2222);
        run_frame(2, 1, 0, 0, 0, 0, ok);
        model_frame(2, 0);
        tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL early_even_count got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            tests++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL early_even_wr[%0d] got %h want %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_ack();
        bit ok;
        do_reset(); rst_n = 1; model_reset();
        fill_random(2 * CAP);
        run_frame(2 * CAP, 0, 0, 0, 0, 0, ok);
        model_frame(2 * CAP, 0);
        fill_random(3);
        run_frame(3, 1, 1, 0, 1, 0, ok);
        model_frame(3, 1);
        tests++; if (!ok) begin fails++; $display("FAIL ack_timeout no frame_done want one"); end
        tests++;
        if ({irq_o, overflow_o, frame_cnt_o} !== {1'b1, 1'b0, 16'd2}) begin
            fails++; $display("FAIL ack_at_done got irq=%0b ovf=%0b cnt=%0d want 1 0 2", irq_o, overflow_o, frame_cnt_o);
        end
        @(posedge clk); #1 irq_ack_in = 1;
        @(posedge clk); #1 irq_ack_in = 0;
        m_irq = 0;
        tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL ack_clear got irq=%0b want 0", irq_o); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int d0 = done_seen;
        got.delete();
        fill_random(4);
        @(posedge clk); #1 start_in = 1;
        @(posedge clk); #1 start_in = 0;
        for (int i = 0; i < 4; i++) begin
            sample_valid_in = 1; sample_in = smp[i];
            @(posedge clk); #1;
        end
        sample_valid_in = 0;
        @(posedge clk); #1;
        tests++; if (got.size() != 2 + HDR) begin fails++; $display("FAIL mid_pre_reset_writes got %0d want %0d", got.size(), 2 + HDR); end
        rst_n = 0;
        @(posedge clk); #1;
        tests++;
        if ({ram_wr_o, ram_addr_o, ram_data_o, frame_done_o, irq_o, buf_sel_o, overflow_o, frame_cnt_o} !== '0) begin
            fails++; $display("FAIL mid_reset_outputs got irq=%0b sel=%0b ovf=%0b cnt=%h wr=%0b want all zero",
                              irq_o, buf_sel_o, overflow_o, frame_cnt_o, ram_wr_o);
        end
        rst_n = 1; model_reset();
        tests++; if (done_seen != d0) begin fails++; $display("FAIL mid_no_done got %0d pulses want 0", done_seen - d0); end
        fill_random(2 * CAP);
        run_frame(2 * CAP, 0, 0, 0, 0, 0, ok);
        model_frame(2 * CAP, 0);
        tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL mid_next_count got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            tests++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL mid_next_wr[%0d] got %h want %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        bit ok, early, ack;
        int n;
        for (int f = 0; f < 10; f++) begin
            early = 1'($urandom_range(0, 1));
            ack   = 1'($urandom_range(0, 1));
            n     = early ? int'($urandom_range(1, 2 * CAP - 1)) : 2 * CAP;
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1 irq_ack_in = 1;
                @(posedge clk); #1 irq_ack_in = 0;
                m_irq = 0;
            end
            fill_random(n);
            run_frame(n, early, 1'($urandom_range(0, 1)), !early, ack, n >= 2, ok);
            model_frame(n, ack);
            tests++; if (!ok) begin fails++; $display("FAIL rnd%0d_timeout no frame_done want one", f); end
            tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL rnd%0d_count got %0d want %0d", f, got.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                tests++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL rnd%0d_wr[%0d] got %h want %h", f, i, got[i], exp_q[i]); end
            end
            tests++;
            if ({irq_o, buf_sel_o, overflow_o, frame_cnt_o} !== {m_irq, m_bsel, m_ovf, m_cnt}) begin
                fails++; $display("FAIL rnd%0d_status got irq=%0b sel=%0b ovf=%0b cnt=%0d want %0b %0b %0b %0d",
                                  f, irq_o, buf_sel_o, overflow_o, frame_cnt_o, m_irq, m_bsel, m_ovf, m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_ping_pong_overflow();
        test_early_end();
        test_ack();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
